window_stream_buffer: RTL and testbench

Streaming 3x3 neighbourhood generator for the display/filter path. It accepts one raster-order pixel per handshake and keeps two line buffers plus a 3x3 shift window. It emits every interior 3x3 window with its centre coordinate over a valid/ready handshake. It replaces per-pixel nine-address fetch sequencing with a single pass over the frame buffer, and feeds `image_processing_uni`-style kernels directly.

---
 rtl/window_stream_buffer.sv | 153 +++++++++++++++
 tb/tb_window_stream_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/window_stream_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 shift window,
// and every interior window is emitted with its centre coordinate over valid/ready.
`timescale 1ns/1ps
module window_stream_buffer #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int PIX_W = 24,
    parameter int XW    = $clog2(IMG_W),
    parameter int YW    = $clog2(IMG_H)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sync_clear,
    input  logic [PIX_W-1:0]   in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [9*PIX_W-1:0] window,
    output logic [XW-1:0]      x_out,
    output logic [YW-1:0]      y_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               frame_done
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic [XW-1:0] ix_reg, ix_next;
    logic [YW-1:0] iy_reg, iy_next;
    logic [XW-1:0] x_out_reg, x_out_next;
    logic [YW-1:0] y_out_reg, y_out_next;
    logic          out_valid_reg, out_valid_next;
    logic          frame_done_reg, frame_done_next;

    logic          accept;
    logic          last_col;
    logic          last_row;

    // Line buffers: lb0 holds the previous row, lb1 the row before that.
    logic [PIX_W-1:0] lb0_mem [0:IMG_W-1];
    logic [PIX_W-1:0] lb1_mem [0:IMG_W-1];
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Incoming window column, index 0 = top row, 2 = bottom row.
    logic [2:0][PIX_W-1:0] new_col;

    // The output register is the only stage, so input stalls exactly when it is full and unread.
    assign in_ready = !sync_clear && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (ix_reg == X_LAST);
    assign last_row = (iy_reg == Y_LAST);

    assign lb0_rd  = lb0_mem[ix_reg];
    assign lb1_rd  = lb1_mem[ix_reg];
    assign new_col = {in_pixel, lb0_rd, lb1_rd};

    always_comb begin
        ix_next = ix_reg;
        iy_next = iy_reg;
        if (sync_clear) begin
            ix_next = '0;
            iy_next = '0;
        end else if (accept) begin
            if (last_col) begin
                ix_next = '0;
                iy_next = last_row ? '0 : iy_reg + Y_ONE;
            end else begin
                ix_next = ix_reg + X_ONE;
            end
        end
    end

    always_comb begin
        out_valid_next  = out_valid_reg;
        frame_done_next = frame_done_reg;
        x_out_next      = x_out_reg;
        y_out_next      = y_out_reg;
        if (sync_clear) begin
            out_valid_next  = 1'b0;
            frame_done_next = 1'b0;
        end else if (accept) begin
            // Centre lags the incoming pixel by one column and one row.
            out_valid_next  = (ix_reg >= X_TWO) && (iy_reg >= Y_TWO);
            frame_done_next = last_col && last_row;
            x_out_next      = ix_reg - X_ONE;
            y_out_next      = iy_reg - Y_ONE;
        end else if (out_ready) begin
            out_valid_next  = 1'b0;
            frame_done_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ix_reg         <= '0;
            iy_reg         <= '0;
            x_out_reg      <= '0;
            y_out_reg      <= '0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            ix_reg         <= ix_next;
            iy_reg         <= iy_next;
            x_out_reg      <= x_out_next;
            y_out_reg      <= y_out_next;
            out_valid_reg  <= out_valid_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // No reset: rows 0 and 1 are always rewritten before they reach an emitted window.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb1_mem[ix_reg] <= lb0_mem[ix_reg];
            lb0_mem[ix_reg] <= in_pixel;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_row
            logic [PIX_W-1:0] left_reg;
            logic [PIX_W-1:0] centre_reg;
            logic [PIX_W-1:0] right_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    left_reg   <= '0;
                    centre_reg <= '0;
                    right_reg  <= '0;
                end else if (accept) begin
                    left_reg   <= centre_reg;
                    centre_reg <= right_reg;
                    right_reg  <= new_col[gi];
                end
            end

            assign window[(3*gi + 0)*PIX_W +: PIX_W] = left_reg;
            assign window[(3*gi + 1)*PIX_W +: PIX_W] = centre_reg;
            assign window[(3*gi + 2)*PIX_W +: PIX_W] = right_reg;
        end
    endgenerate

    assign x_out      = x_out_reg;
    assign y_out      = y_out_reg;
    assign out_valid  = out_valid_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_window_stream_buffer.sv
// Scoreboard bench for window_stream_buffer: a pixel-formula golden model pushes the
// expected window on every accepted interior pixel; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_window_stream_buffer;

    localparam int IMG_W = 13;
    localparam int IMG_H = 9;
    localparam int PIX_W = 16;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int WB    = 9 * PIX_W;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);

    logic               clock = 1'b0;
    logic               reset;
    logic               sync_clear;
    logic [PIX_W-1:0]   in_pixel;
    logic               in_valid;
    logic               in_ready;
    logic [9*PIX_W-1:0] window;
    logic [XW-1:0]      x_out;
    logic [YW-1:0]      y_out;
    logic               out_valid;
    logic               out_ready;
    logic               frame_done;

    window_stream_buffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .XW(XW), .YW(YW)
    ) dut (
        .clock(clock), .reset(reset), .sync_clear(sync_clear),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .window(window), .x_out(x_out), .y_out(y_out),
        .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [WB-1:0] win;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          done;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_win = 0;
    int   n_done = 0;
    int   cyc = 0;
    bit   rand_ready = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [PIX_W-1:0] pix(int seed, int x, int y);
        int v;
        v = (seed * 7919 + y * IMG_W + x) * 40503;
        return PIX_W'(v);
    endfunction

    function automatic exp_t mk(int seed, int cx, int cy);
        exp_t e;
        e.win = '0;
        for (int k = 0; k < 9; k++)
            e.win[k*PIX_W +: PIX_W] = pix(seed, cx - 1 + k % 3, cy - 1 + k / 3);
        e.x    = XW'(cx);
        e.y    = YW'(cy);
        e.done = (cx == IMG_W - 2) && (cy == IMG_H - 2);
        return e;
    endfunction

    task automatic chk(string tag, logic [WB-1:0] obs, logic [WB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares the head entry whenever a window is presented, pops on consume.
    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready", WB'(in_ready), WB'(!sync_clear && (!out_valid || out_ready)));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", WB'(out_valid), WB'(0));
                end else begin
                    chk("window", window, sb[0].win);
                    chk("x_out", WB'(x_out), WB'(sb[0].x));
                    chk("y_out", WB'(y_out), WB'(sb[0].y));
                    chk("frame_done", WB'(frame_done), WB'(sb[0].done));
                    if (out_ready) begin
                        sb.delete(0);
                        n_win++;
                        if (frame_done) n_done++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic send_pixel(int seed, int x, int y, int gap);
        bit acc;
        acc = 0;
        in_pixel = pix(seed, x, y);
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1;
                if (x >= 2 && y >= 2) sb.push_back(mk(seed, x - 1, y - 1));
            end
            step();
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", WB'(acc), WB'(1));
        for (int g = 0; g < gap; g++) step();
    endtask

    task automatic send_pixels(int seed, int count, int gap);
        for (int i = 0; i < count; i++) send_pixel(seed, i % IMG_W, i / IMG_W, gap);
    endtask

    task automatic drain(string tag);
        rand_ready = 0;
        for (int t = 0; t < 100 && (sb.size() != 0 || out_valid); t++) step();
        chk({tag, "_queue_empty"}, WB'(sb.size()), WB'(0));
        chk({tag, "_idle"}, WB'(out_valid), WB'(0));
    endtask

    int w0, d0, c0;

    initial begin
        reset = 1'b1; sync_clear = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b1;
        #1;
        chk("rst_window", window, WB'(0));
        chk("rst_x_out", WB'(x_out), WB'(0));
        chk("rst_y_out", WB'(y_out), WB'(0));
        chk("rst_out_valid", WB'(out_valid), WB'(0));
        chk("rst_frame_done", WB'(frame_done), WB'(0));
        chk("rst_in_ready", WB'(in_ready), WB'(1));
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Two frames back to back, full rate.
        w0 = n_win; d0 = n_done; c0 = cyc;
        send_pixels(0, NPIX, 0);
        send_pixels(1, NPIX, 0);
        chk("throughput_cycles", WB'(cyc - c0), WB'(2 * NPIX));
        chk("last_latency_valid", WB'(out_valid), WB'(1));
        chk("last_latency_done", WB'(frame_done), WB'(1));
        drain("b2b");
        chk("b2b_windows", WB'(n_win - w0), WB'(2 * NWIN));
        chk("b2b_done_pulses", WB'(n_done - d0), WB'(2));

        // Random downstream backpressure.
        w0 = n_win; d0 = n_done;
        rand_ready = 1;
        send_pixels(2, NPIX, 0);
        drain("bp");
        chk("bp_windows", WB'(n_win - w0), WB'(NWIN));
        chk("bp_done_pulses", WB'(n_done - d0), WB'(1));

        // Input gaps, one valid cycle in three.
        w0 = n_win; d0 = n_done;
        send_pixels(3, NPIX, 2);
        drain("gap");
        chk("gap_windows", WB'(n_win - w0), WB'(NWIN));
        chk("gap_done_pulses", WB'(n_done - d0), WB'(1));

        // sync_clear mid-row with a simultaneous valid pixel.
        send_pixels(4, 4 * IMG_W + 6, 0);
        sync_clear = 1'b1;
        in_valid = 1'b1;
        in_pixel = pix(4, 6, 4);
        @(negedge clock);
        chk("sync_in_ready", WB'(in_ready), WB'(0));
        step();
        sync_clear = 1'b0;
        in_valid = 1'b0;
        chk("sync_out_valid", WB'(out_valid), WB'(0));
        chk("sync_frame_done", WB'(frame_done), WB'(0));
        sb.delete();
        w0 = n_win; d0 = n_done;
        send_pixels(5, NPIX, 0);
        drain("sync");
        chk("sync_windows", WB'(n_win - w0), WB'(NWIN));
        chk("sync_done_pulses", WB'(n_done - d0), WB'(1));

        // Asynchronous reset between clock edges mid-frame.
        send_pixels(6, 3 * IMG_W + 4, 0);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("arst_window", window, WB'(0));
        chk("arst_x_out", WB'(x_out), WB'(0));
        chk("arst_y_out", WB'(y_out), WB'(0));
        chk("arst_out_valid", WB'(out_valid), WB'(0));
        chk("arst_frame_done", WB'(frame_done), WB'(0));
        chk("arst_in_ready", WB'(in_ready), WB'(1));
        sb.delete();
        @(posedge clock);
        #3 reset = 1'b0;
        w0 = n_win; d0 = n_done;
        send_pixels(7, NPIX, 0);
        drain("arst");
        chk("arst_windows", WB'(n_win - w0), WB'(NWIN));
        chk("arst_done_pulses", WB'(n_done - d0), WB'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
